// File: rtl/tdo_serializer.sv
// -----------------------------------------------------------------------------
// tdo_serializer
//
// Shifts a WIDTH-bit word out one bit per enabled tck edge and routes either
// that bit or a TAP-controller bit to the TDO pin.
//
// Build option:
//   TDO_SERIALIZER_MSB_FIRST_EN  defined   -> word is sent MSB first
//                                undefined -> word is sent LSB first (default)
//   Counter, done timing and the output mux are identical in both builds.
//
// Ports:
//   tck        in   clock, all state changes on the rising edge
//   trst_n     in   synchronous active-low reset (highest priority)
//   restart    in   synchronous clear of the serializer, active-high;
//                   the output mux is unaffected
//   enable     in   advance one bit per rising edge while high
//   in         in   [WIDTH] word to send; hold stable from first enabled edge
//                   until done
//   tap_bit    in   bit driven by the TAP controller
//   select_tap in   1 = tap_bit to tdo, 0 = ser_out to tdo
//   ser_out    out  registered serializer bit
//   done       out  registered, rises together with the last bit on ser_out
//   tdo        out  combinational mux output
//
// Pacing: there is no ready/acknowledge. Every rising edge with enable=1
// and done=0 consumes exactly one bit; enable=0 freezes all state, so a
// pause anywhere in the word loses nothing. After done the block holds
// until trst_n or restart.
// -----------------------------------------------------------------------------
module tdo_serializer #(
    parameter int WIDTH = 32
) (
    input  logic             tck,
    input  logic             trst_n,
    input  logic             restart,
    input  logic             enable,
    input  logic [WIDTH-1:0] in,
    input  logic             tap_bit,
    input  logic             select_tap,
    output logic             ser_out,
    output logic             done,
    output logic             tdo
);

    // Counter only has to reach WIDTH-1, it never wraps.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] bit_cnt;
    logic [CW-1:0] bit_cnt_d;
    logic [CW-1:0] bit_idx;
    logic          ser_d;
    logic          done_d;

    // Map the transmit position onto a bit index of the word.
`ifdef TDO_SERIALIZER_MSB_FIRST_EN
    assign bit_idx = LAST - bit_cnt;
`else
    assign bit_idx = bit_cnt;
`endif

    always_comb begin
        bit_cnt_d = bit_cnt;
        ser_d     = ser_out;
        done_d    = done;
        if (enable && !done) begin
            ser_d = in[bit_idx];
            // The last bit and done land on the same edge; the counter
            // saturates so ser_out keeps showing the final bit.
            if (bit_cnt == LAST) begin
                done_d = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge tck) begin
        if (!trst_n || restart) begin
            bit_cnt <= '0;
            ser_out <= 1'b0;
            done    <= 1'b0;
        end else begin
            bit_cnt <= bit_cnt_d;
            ser_out <= ser_d;
            done    <= done_d;
        end
    end

    assign tdo = select_tap ? tap_bit : ser_out;

endmodule

// File: tb/tb_tdo_serializer.sv
// -----------------------------------------------------------------------------
// tb_tdo_serializer
//
// Directed bench for tdo_serializer. Each driven edge pushes the expected
// {done, ser_out} pair into a queue; after the edge the pair is popped and
// compared against the outputs. Also checks the combinational tdo mux.
// Honours TDO_SERIALIZER_MSB_FIRST_EN for the expected bit order.
// -----------------------------------------------------------------------------
module tb_tdo_serializer;

    localparam int WIDTH = 32;

    logic             tck = 1'b0;
    logic             trst_n = 1'b0;
    logic             restart = 1'b0;
    logic             enable = 1'b0;
    logic [WIDTH-1:0] in = '0;
    logic             tap_bit = 1'b0;
    logic             select_tap = 1'b0;
    logic             ser_out;
    logic             done;
    logic             tdo;

    int n_checks = 0;
    int n_err    = 0;

    // Reference state.
    int   m_cnt  = 0;
    logic m_ser  = 1'b0;
    logic m_done = 1'b0;

    logic [1:0] exp_q[$];

    tdo_serializer #(.WIDTH(WIDTH)) dut (
        .tck        (tck),
        .trst_n     (trst_n),
        .restart    (restart),
        .enable     (enable),
        .in         (in),
        .tap_bit    (tap_bit),
        .select_tap (select_tap),
        .ser_out    (ser_out),
        .done       (done),
        .tdo        (tdo)
    );

    // ---------------- clock ----------------
    always #5 tck = ~tck;

    // ---------------- helpers ----------------
    function automatic logic exp_bit(input logic [WIDTH-1:0] w, input int k);
`ifdef TDO_SERIALIZER_MSB_FIRST_EN
        return w[WIDTH-1-k];
`else
        return w[k];
`endif
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One rising edge with the given controls; expectation queued before
    // the edge, compared #1 after it.
    task automatic tick(input logic en, input logic rst_n, input logic rs,
                        input string tag);
        logic [1:0] e;
        enable  = en;
        trst_n  = rst_n;
        restart = rs;
        if (!rst_n || rs) begin
            m_cnt  = 0;
            m_ser  = 1'b0;
            m_done = 1'b0;
        end else if (en && !m_done) begin
            m_ser = exp_bit(in, m_cnt);
            if (m_cnt == WIDTH - 1) m_done = 1'b1;
            else m_cnt++;
        end
        exp_q.push_back({m_done, m_ser});
        @(posedge tck);
        #1;
        e = exp_q.pop_front();
        check({tag, ".ser_out"}, ser_out, e[0]);
        check({tag, ".done"}, done, e[1]);
        check({tag, ".tdo"}, tdo, select_tap ? tap_bit : e[0]);
        trst_n  = 1'b1;
        restart = 1'b0;
    endtask

    task automatic run_enabled(input int n, input string tag);
        for (int i = 0; i < n; i++) tick(1'b1, 1'b1, 1'b0, tag);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset with enable high; reset must win.
        select_tap = 1'b0;
        @(negedge tck);
        tick(1'b1, 1'b0, 1'b0, "reset");
        check("reset.ser_out_zero", ser_out, 1'b0);
        check("reset.done_zero", done, 1'b0);
        check("reset.tdo_zero", tdo, 1'b0);

        // Full word, enable held high, then extra enabled edges.
        in = 32'h000FAF01;
        run_enabled(31, "full");
        check("full.not_done_before_32", done, 1'b0);
        run_enabled(1, "full_last");
        check("full.done_at_32", done, 1'b1);
`ifndef TDO_SERIALIZER_MSB_FIRST_EN
        check("full.last_bit", ser_out, 1'b0);
`endif
        run_enabled(3, "full_hold");

        // Pause after bit 9 for three cycles.
        tick(1'b1, 1'b1, 1'b1, "pause_restart");
        run_enabled(9, "pause_pre");
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0, "pause_idle");
        run_enabled(22, "pause_post");
        check("pause.not_done_31", done, 1'b0);
        run_enabled(1, "pause_last");
        check("pause.done_32", done, 1'b1);

        // Restart mid-word, then replay the whole word.
        tick(1'b1, 1'b1, 1'b1, "rs_clear");
        run_enabled(5, "rs_pre");
        tick(1'b1, 1'b1, 1'b1, "rs_mid");
        check("rs.ser_zero", ser_out, 1'b0);
        check("rs.done_zero", done, 1'b0);
        run_enabled(32, "rs_replay");
        check("rs.done_after_replay", done, 1'b1);

        // Reset mid-word aborts as well.
        tick(1'b1, 1'b1, 1'b1, "trst_clear");
        run_enabled(7, "trst_pre");
        tick(1'b1, 1'b0, 1'b0, "trst_mid");
        run_enabled(3, "trst_post");

        // Mux: tap_bit toggling while serializing; changes seen without a clock.
        select_tap = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tap_bit = i[0];
            tick(1'b1, 1'b1, 1'b0, "mux_tap");
            tap_bit = ~tap_bit;
            #1;
            check("mux.tap_same_cycle", tdo, tap_bit);
        end
        select_tap = 1'b0;
        #1;
        check("mux.sel_ser", tdo, m_ser);
        select_tap = 1'b1;
        #1;
        check("mux.sel_tap", tdo, tap_bit);
        select_tap = 1'b0;

        // Bit-order boundary word: both end bits set.
        tick(1'b1, 1'b1, 1'b1, "edge_clear");
        in = 32'h80000001;
        run_enabled(1, "edge_first");
        check("edge.first_bit", ser_out, 1'b1);
        run_enabled(30, "edge_mid");
        check("edge.bit31_zero", ser_out, 1'b0);
        run_enabled(1, "edge_last");
        check("edge.last_bit", ser_out, 1'b1);
        check("edge.done", done, 1'b1);

        // Random word with random enable pacing.
        tick(1'b1, 1'b1, 1'b1, "rnd_clear");
        in = $urandom();
        for (int i = 0; i < 80; i++) begin
            select_tap = ($urandom_range(0, 3) == 0);
            tap_bit    = $urandom_range(0, 1);
            tick(($urandom_range(0, 2) != 0), 1'b1, 1'b0, "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/tdo_serializer.md
Name: tdo_serializer

Overview:
- Serializes a fixed-width data word (e.g. a 32-bit IDCODE) one bit per clock onto a single-bit output.
- Passes that bit through a 2:1 output mux that picks either the serializer bit or a controller-driven bit for the TDO pin.
- Sits between the TAP state machine and the TDO pad.
- Shifting is paced by an enable input; completion is signalled by a done flag.

Parameters:
- WIDTH, 32, number of bits in the word to transmit (≥2).

Ports:
- tck  input  1  clock; all state updates on rising edge.
- trst_n  input  1  reset, synchronous, active-low.
- restart  input  1  synchronous clear of the serializer, active-high; does not affect the mux.
- enable  input  1  advance one bit per rising edge while high.
- in  input  WIDTH  word to transmit; must be held stable from first enabled edge until done.
- tap_bit  input  1  bit driven by the TAP controller.
- select_tap  input  1  mux select: 1 = tap_bit to tdo, 0 = serializer bit to tdo.
- ser_out  output  1  registered serializer bit.
- done  output  1  registered; high once the last bit has been presented.
- tdo  output  1  combinational mux output.

Behaviour:
- Reset (trst_n=0 at a rising edge):
  - bit counter = 0, ser_out = 0, done = 0.
  - Reset has priority over restart and enable.
- restart=1 (trst_n=1): same clearing as reset. Priority over enable.
- Counter:
  - Width is clog2(WIDTH) bits, or wide enough to hold WIDTH−1.
  - Never wraps: saturates at WIDTH−1 and holds while done=1.
- Enabled edge, done=0, counter=k:
  - ser_out <= in[k] (LSB first), counter <= k+1.
  - When k = WIDTH−1: done <= 1 on the same edge, so done rises together with the last bit on ser_out; counter stays at WIDTH−1.
- Enabled edge, done=1: ser_out, counter and done all hold (ser_out keeps in[WIDTH−1]). No retransmission until reset or restart.
- enable=0: ser_out, counter and done all hold, so pausing mid-word is lossless. The next enabled edge continues with bit k.
- Latency: bit k appears on ser_out after the (k+1)-th enabled edge; a full word takes WIDTH enabled edges.
- Reset or restart mid-word: transmission aborts; the next word starts at bit 0.
- Mux:
  - tdo = select_tap ? tap_bit : ser_out.
  - Purely combinational, no clock or reset; a select change is visible in the same cycle.
- No X may reach ser_out or done after the first reset edge.

Optional Feature:
- Macro TDO_SERIALIZER_MSB_FIRST_EN.
- Defined: bit order reversed. Enabled edge k presents in[WIDTH−1−k]; the last bit presented is in[0], and ser_out holds in[0] after done.
- Undefined (default): LSB first as above.
- Counter, done timing and mux are identical in both builds.

Test Plan:
- Reset: trst_n=0 one edge with enable=1, select_tap=0 → ser_out=0, done=0, tdo=0.
- Full word, WIDTH=32, in=32'h000FAF01, enable held high:
  - ser_out after edges 1..20 = 1,0,0,0,0,0,0,0,1,1,1,1,0,1,0,1,1,1,1,1.
  - ser_out after edges 21..32 = 0.
  - done=1 exactly after edge 32, not before; extra enabled edges hold ser_out=0, done=1.
- Pause: same word, enable low for 3 cycles after edge 9 → ser_out holds 1, counter holds; edge 10 resumes with bit 9 = 1; done after the 32nd enabled edge.
- Restart mid-word: restart=1 after 5 bits → ser_out=0, done=0; the next 32 enabled edges replay the full sequence from bit 0.
- Mux: select_tap=1, tap_bit toggles 0/1 while serializing → tdo follows tap_bit in the same cycle. select_tap=0 → tdo equals ser_out.
- MSB-first build (TDO_SERIALIZER_MSB_FIRST_EN), in=32'h80000001 → first bit 1, bits 2..31 = 0, 32nd bit 1 with done=1.
